// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage MIPS pipeline: req/ack data-memory port, lane steering, load extension, stall.
// Optional misaligned-access trap enabled by defining MISALIGN_TRAP_EN.
module mem_access_stage #(
    parameter int MAX_WAIT = 255,
    parameter int WAIT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ex_mem_instr,
    input  logic [31:0] ex_mem_alu_result,
    input  logic [31:0] ex_mem_alu_in_out,
    input  logic        ex_mem_mem_read,
    input  logic        ex_mem_mem_write,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] mem_read_data,
    output logic        mem_stall,
    output logic        dmem_timeout,
    output logic        misalign_exc
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MAX_WAIT - 1);

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [1:0]        off_q;
    logic [1:0]        size_q;
    logic              unsigned_q;

    logic [5:0]  opcode;
    logic [1:0]  size;
    logic        is_unsigned;
    logic [1:0]  off;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic        access_req;
    logic        misaligned;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_value;

    logic unused_instr_bits;
    assign unused_instr_bits = ^ex_mem_instr[25:0];

    // Decode size/sign from the opcode and steer the store data onto byte lanes.
    always_comb begin
        opcode      = ex_mem_instr[31:26];
        off         = ex_mem_alu_result[1:0];
        access_req  = ex_mem_mem_read | ex_mem_mem_write;
        size        = SZ_WORD;
        is_unsigned = (opcode == 6'b100100) || (opcode == 6'b100101);
        case (opcode)
            6'b100000, 6'b100100, 6'b101000: size = SZ_BYTE;
            6'b100001, 6'b100101, 6'b101001: size = SZ_HALF;
            default:                         size = SZ_WORD;
        endcase
        case (size)
            SZ_BYTE: begin
                be_next    = 4'b0001 << off;
                wdata_next = {4{ex_mem_alu_in_out[7:0]}};
            end
            SZ_HALF: begin
                be_next    = off[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{ex_mem_alu_in_out[15:0]}};
            end
            default: begin
                be_next    = 4'b1111;
                wdata_next = ex_mem_alu_in_out;
            end
        endcase
`ifdef MISALIGN_TRAP_EN
        misaligned = ((size == SZ_HALF) && off[0]) || ((size == SZ_WORD) && (off != 2'b00));
`else
        misaligned = 1'b0;
`endif
    end

    // Extract and extend the returned lane using the size/offset captured at issue.
    always_comb begin
        byte_sel = dmem_rdata[{off_q, 3'b000} +: 8];
        half_sel = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (size_q)
            SZ_BYTE: load_value = unsigned_q ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            SZ_HALF: load_value = unsigned_q ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: load_value = dmem_rdata;
        endcase
    end

    assign mem_stall = ((state == IDLE) && access_req && !misaligned) || (state == ACCESS);

`ifdef MISALIGN_TRAP_EN
    assign misalign_exc = (state == IDLE) && access_req && misaligned;
`else
    assign misalign_exc = 1'b0;
`endif

    // DONE always separates accesses so the still-held EX/MEM instruction is never re-issued.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            off_q         <= 2'b00;
            size_q        <= SZ_WORD;
            unsigned_q    <= 1'b0;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= 32'b0;
            dmem_be       <= 4'b0;
            dmem_wdata    <= 32'b0;
            mem_read_data <= 32'b0;
            dmem_timeout  <= 1'b0;
        end else begin
            dmem_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (access_req) begin
                        if (misaligned) begin
                            state <= DONE;
                        end else begin
                            dmem_req   <= 1'b1;
                            dmem_we    <= ex_mem_mem_write;
                            dmem_addr  <= {ex_mem_alu_result[31:2], 2'b00};
                            dmem_be    <= be_next;
                            dmem_wdata <= wdata_next;
                            off_q      <= off;
                            size_q     <= size;
                            unsigned_q <= is_unsigned;
                            wait_cnt   <= '0;
                            state      <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        if (!dmem_we) begin
                            mem_read_data <= load_value;
                        end
                        state <= DONE;
                    end else if (wait_cnt == LAST_WAIT) begin
                        dmem_req     <= 1'b0;
                        dmem_timeout <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
